// File: rtl/freq_counter_bcd.sv
// freq_counter_bcd: debounced rising-edge counter over a gate window, BCD result
// Ports:
//   iClk      - system clock, rising edge
//   iRst_n    - asynchronous active-low reset
//   iSenal    - asynchronous noisy input
//   iEnable   - measurement enable (level)
//   oDigits   - latched BCD result, digit 0 (units) in [3:0]
//   oValid    - one-cycle strobe when oDigits/oOverflow update
//   oOverflow - latched: window count exceeded 10^DIGITS-1
//   oBusy     - high while counting
// Optional: define FREQCNT_BLANK_EN to replace leading zero digits with 4'hF.
module freq_counter_bcd #(
    parameter int DEBOUNCE_CYCLES = 10,
    parameter int GATE_CYCLES     = 50000000,
    parameter int DIGITS          = 4
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    input  logic                  iSenal,
    input  logic                  iEnable,
    output logic [4*DIGITS-1:0]   oDigits,
    output logic                  oValid,
    output logic                  oOverflow,
    output logic                  oBusy
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int GW = $clog2(GATE_CYCLES);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

    typedef enum logic {IDLE, COUNT} state_t;

    state_t              state_q, state_d;
    logic                sync1_q, sync1_d, sync2_q, sync2_d;
    logic                filt_q, filt_d, rise_q, rise_d;
    logic [DW-1:0]       db_cnt_q, db_cnt_d;
    logic [GW-1:0]       gate_q, gate_d;
    logic [4*DIGITS-1:0] acc_q, acc_d, acc_inc, acc_nx, shown;
    logic [4*DIGITS-1:0] digits_q, digits_d;
    logic                wovf_q, wovf_d, wovf_nx;
    logic                valid_q, valid_d, ovf_q, ovf_d;
    logic                carry;

    // Synchroniser, debouncer and rising-edge detect run in every state.
    always_comb begin
        sync1_d  = iSenal;
        sync2_d  = sync1_q;
        filt_d   = filt_q;
        db_cnt_d = '0;
        if (sync2_q != filt_q) begin
            if (db_cnt_q == DB_LAST) filt_d = ~filt_q;
            else db_cnt_d = db_cnt_q + 1'b1;
        end
        rise_d = filt_d & ~filt_q;
    end

    // Ripple BCD increment; carry left set means every digit was 9.
    always_comb begin
        acc_inc = acc_q;
        carry   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (acc_q[4*i +: 4] == 4'd9) acc_inc[4*i +: 4] = 4'd0;
                else begin
                    acc_inc[4*i +: 4] = acc_q[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    // Accumulator value including a rise in the current cycle; saturates at all 9s.
    always_comb begin
        acc_nx  = acc_q;
        wovf_nx = wovf_q;
        if (rise_q) begin
            if (carry) wovf_nx = 1'b1;
            else acc_nx = acc_inc;
        end
    end

`ifdef FREQCNT_BLANK_EN
    logic lead;
    always_comb begin
        shown = acc_nx;
        lead  = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (lead && acc_nx[4*i +: 4] == 4'd0) shown[4*i +: 4] = 4'hF;
            else lead = 1'b0;
        end
    end
`else
    always_comb shown = acc_nx;
`endif

    // Window control: last gate cycle latches the result and restarts with no dead cycle.
    always_comb begin
        state_d  = state_q;
        gate_d   = '0;
        acc_d    = '0;
        wovf_d   = 1'b0;
        valid_d  = 1'b0;
        digits_d = digits_q;
        ovf_d    = ovf_q;
        if (state_q == IDLE) state_d = iEnable ? COUNT : IDLE;
        else if (!iEnable) state_d = IDLE;
        else if (gate_q == GATE_LAST) begin
            valid_d  = 1'b1;
            digits_d = shown;
            ovf_d    = wovf_nx;
        end else begin
            gate_d = gate_q + 1'b1;
            acc_d  = acc_nx;
            wovf_d = wovf_nx;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q  <= IDLE;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            filt_q   <= 1'b0;
            rise_q   <= 1'b0;
            db_cnt_q <= '0;
            gate_q   <= '0;
            acc_q    <= '0;
            wovf_q   <= 1'b0;
            digits_q <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            filt_q   <= filt_d;
            rise_q   <= rise_d;
            db_cnt_q <= db_cnt_d;
            gate_q   <= gate_d;
            acc_q    <= acc_d;
            wovf_q   <= wovf_d;
            digits_q <= digits_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    assign oDigits   = digits_q;
    assign oValid    = valid_q;
    assign oOverflow = ovf_q;
    assign oBusy     = (state_q == COUNT);
endmodule

// File: tb/tb_freq_counter_bcd.sv
// tb_freq_counter_bcd: directed checks of the debounced BCD frequency counter
module tb_freq_counter_bcd;
    localparam int D  = 3;
    localparam int G  = 100;
    localparam int GB = 1000;

    logic       iClk = 1'b0, iRst_n = 1'b0, iSenal = 1'b0, iEnable = 1'b0;
    logic [7:0] dig, dig_b;
    logic       val, ovf, busy, val_b, ovf_b, busy_b;

    freq_counter_bcd #(.DEBOUNCE_CYCLES(D), .GATE_CYCLES(G), .DIGITS(2)) dut (
        .iClk(iClk), .iRst_n(iRst_n), .iSenal(iSenal), .iEnable(iEnable),
        .oDigits(dig), .oValid(val), .oOverflow(ovf), .oBusy(busy));

    freq_counter_bcd #(.DEBOUNCE_CYCLES(D), .GATE_CYCLES(GB), .DIGITS(2)) dut_big (
        .iClk(iClk), .iRst_n(iRst_n), .iSenal(iSenal), .iEnable(iEnable),
        .oDigits(dig_b), .oValid(val_b), .oOverflow(ovf_b), .oBusy(busy_b));

    always #5 iClk = ~iClk;

    int hi = 5, lo = 5, goff = 0, glen = 0;
    int ph = 0;

    // Square wave generator with an optional inverted glitch at a fixed phase.
    initial forever begin
        @(negedge iClk);
        ph = (ph + 1) % (hi + lo);
        iSenal = (ph < hi) ^ (glen > 0 && ph >= goff && ph < goff + glen);
    end

    int checks = 0, passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] disp(input logic [7:0] v);
`ifdef FREQCNT_BLANK_EN
        return (v[7:4] == 4'd0) ? {4'hF, v[3:0]} : v;
`else
        return v;
`endif
    endfunction

    // Cycles until the selected oValid is seen, -1 on timeout.
    task automatic wait_valid(input bit big, input int limit, output int n);
        n = 0;
        do begin
            @(negedge iClk);
            n++;
        end while (!(big ? val_b : val) && n < limit);
        if (!(big ? val_b : val)) n = -1;
    endtask

    task automatic restart();
        iRst_n  = 1'b0;
        iEnable = 1'b0;
        repeat (2) @(negedge iClk);
        iRst_n  = 1'b1;
        iEnable = 1'b1;
    endtask

    typedef struct {
        int         hi, lo, goff, glen;
        logic [7:0] bcd;
    } vec_t;

    vec_t v[10];

    initial begin
        int n, cnt;
        v[0] = '{5, 5, 0, 0, 8'h10};
        v[1] = '{4, 6, 0, 0, 8'h10};
        v[2] = '{10, 10, 0, 0, 8'h05};
        v[3] = '{12, 13, 0, 0, 8'h04};
        v[4] = '{25, 25, 0, 0, 8'h02};
        v[5] = '{50, 50, 0, 0, 8'h01};
        v[6] = '{10, 10, 17, 2, 8'h05};
        v[7] = '{10, 10, 7, 2, 8'h05};
        v[8] = '{5, 15, 12, 1, 8'h05};
        v[9] = '{0, 100, 0, 0, 8'h00};

        repeat (2) @(negedge iClk);
        chk("rst_digits", dig, 0);
        chk("rst_valid", val, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_busy", busy, 0);
        chk("rst_busy_big", busy_b, 0);

        for (int i = 0; i < 10; i++) begin
            hi = v[i].hi; lo = v[i].lo; goff = v[i].goff; glen = v[i].glen;
            restart();
            wait_valid(0, 250, n);
            wait_valid(0, 250, n);
            chk($sformatf("vec%0d_interval", i), n, G);
            chk($sformatf("vec%0d_digits", i), dig, disp(v[i].bcd));
            chk($sformatf("vec%0d_ovf", i), ovf, 0);
        end

        // Abort mid-window, then re-enable
        hi = 5; lo = 5; glen = 0;
        restart();
        wait_valid(0, 250, n);
        wait_valid(0, 250, n);
        chk("abort_pre_digits", dig, disp(8'h10));
        repeat (49) @(negedge iClk);
        chk("abort_busy_before", busy, 1);
        iEnable = 1'b0;
        @(negedge iClk);
        chk("abort_busy_after", busy, 0);
        hi = 10; lo = 10;
        cnt = 0;
        repeat (150) begin
            @(negedge iClk);
            if (val) cnt++;
        end
        chk("abort_no_valid", cnt, 0);
        chk("abort_digits_held", dig, disp(8'h10));
        iEnable = 1'b1;
        wait_valid(0, 300, n);
        chk("reenable_latency", n, G + 1);
        chk("reenable_digits", dig, disp(8'h05));

        // Reset pulse mid-window with enable held high
        hi = 5; lo = 5;
        wait_valid(0, 250, n);
        repeat (40) @(negedge iClk);
        iRst_n = 1'b0;
        #1;
        chk("midrst_digits", dig, 0);
        chk("midrst_valid", val, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ovf_big", ovf_b, 0);
        @(negedge iClk);
        iRst_n = 1'b1;
        wait_valid(0, 300, n);
        chk("midrst_latency", n, G + 1);

        // Saturation on the long window, then a clean in-range window
        hi = 4; lo = 4;
        restart();
        wait_valid(1, 1200, n);
        chk("big_first_latency", n, GB + 1);
        chk("big_sat_digits", dig_b, disp(8'h99));
        chk("big_sat_ovf", ovf_b, 1);
        hi = 10; lo = 10;
        wait_valid(1, 1200, n);
        wait_valid(1, 1200, n);
        chk("big_interval", n, GB);
        chk("big_50_digits", dig_b, disp(8'h50));
        chk("big_50_ovf", ovf_b, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/freq_counter_bcd.md
Name: freq_counter_bcd

Overview:
Parametrised successor to the single-digit frequency counter. It debounces the noisy input `iSenal`, counts its qualified rising edges over a programmable gate window, and presents the result as DIGITS packed BCD digits with a one-cycle valid strobe and an overflow flag. It feeds the seven-segment display path directly.

Parameters:
- DEBOUNCE_CYCLES, 10: number of consecutive clocks the synchronised input must differ from the filtered level before the filtered level flips. Must be ≥1.
- GATE_CYCLES, 50000000: gate window length in clocks. Must be ≥2.
- DIGITS, 4: number of BCD digits in the result. Must be ≥1.

Ports:
- iClk  in  1  system clock, rising edge.
- iRst_n  in  1  asynchronous active-low reset.
- iSenal  in  1  asynchronous, noisy input signal.
- iEnable  in  1  measurement enable, level-sensitive.
- oDigits  out  4*DIGITS  latched result; digit 0 (units) in [3:0].
- oValid  out  1  one-cycle strobe when oDigits/oOverflow update.
- oOverflow  out  1  latched: window count exceeded 10^DIGITS-1.
- oBusy  out  1  high while in COUNT.

Behaviour:
- Reset (async assert, sync release): synchroniser = 0, filtered level = 0, debounce counter = 0, gate counter = 0, BCD accumulator = 0, state IDLE, oDigits = 0, oValid = 0, oOverflow = 0, oBusy = 0.
- Input path: 2-FF synchroniser, then debouncer.
  - Debounce counter clears whenever sync == filtered.
  - Otherwise it increments; when it reaches DEBOUNCE_CYCLES, the filtered level toggles and the counter clears.
  - Pulses shorter than DEBOUNCE_CYCLES clocks never propagate.
- Edge detect: one-cycle `rise` when filtered goes 0→1. Latency from a clean iSenal rise to `rise` = 2 + DEBOUNCE_CYCLES clocks.
- FSM states: IDLE, COUNT.
  - IDLE: gate counter and accumulator held at 0; oBusy = 0. If iEnable = 1, go to COUNT next cycle.
  - COUNT: oBusy = 1. Gate counter runs 0..GATE_CYCLES-1. Each `rise` increments the accumulator.
    - On the cycle where gate counter == GATE_CYCLES-1, the next edge latches oDigits and oOverflow (including any `rise` in that same cycle) and pulses oValid.
    - On that same edge, gate counter and accumulator clear. There is no dead cycle between windows.
  - COUNT with iEnable = 0: abort. Return to IDLE next cycle, clear gate counter and accumulator, no oValid, oDigits/oOverflow hold their previous values.
- BCD accumulator: cascaded digits; a digit at 9 rolls to 0 and carries into the next.
  - If all digits are 9 and another `rise` arrives, the accumulator saturates at all 9s and the sticky window-overflow bit sets.
  - Window-overflow is copied to oOverflow at latch time and cleared with the accumulator.
- oValid is high for exactly one cycle per completed window; it is never asserted in IDLE.
- The debouncer runs in all states, so the filtered level stays valid across enable toggles.
- Reset mid-window: all state clears immediately, and no oValid is produced for the partial window.

Optional Feature:
FREQCNT_BLANK_EN.
- Defined: at latch time, leading zero digits (most significant downward, stopping at the first non-zero digit) are replaced by 4'hF, the display blank code. Digit 0 is never blanked, so a count of 0 shows as blanks followed by 0.
- Not defined: oDigits is pure BCD with zeros shown.
- Blanking affects oDigits only; oOverflow and oValid timing are unchanged.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=3, GATE_CYCLES=100, DIGITS=2 unless stated.
- Square wave, 5 clocks high / 5 low, iEnable=1 → each oValid (every 100 clocks) shows oDigits=8'h10, oOverflow=0.
- Square wave as above plus 1–2-clock glitches injected → oDigits still 8'h10; glitches are not counted.
- GATE_CYCLES=1000, 4 high / 4 low wave (125 edges) → oDigits=8'h99, oOverflow=1. The next window at 10 high / 10 low gives 8'h50, oOverflow=0.
- iEnable dropped at clock 50 of a window → no oValid, oBusy falls within 1 clock, oDigits keeps its prior value. Re-enable → the first oValid arrives 100 clocks after COUNT entry.
- iRst_n pulsed low mid-window → all outputs 0 immediately; with iEnable held high, the counter restarts and its first oValid arrives 101 clocks after reset release.
- FREQCNT_BLANK_EN defined, 5 edges per window → oDigits=8'hF5. With 0 edges per window → 8'hF0.
